io_bus_arbiter: RTL

Two-requester arbiter and bus sequencer for the external IO device port. It grants the single IO port to requester 0 (CPU memory stage) or requester 1 (secondary master, e.g. DMA/debug) using round-robin. It generates the IO `cs`/`rd`/`wr` strobes, address and write data. It waits for the IO `rdy` on reads and returns read data with a one-cycle acknowledge.

---
 rtl/io_bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter and IO strobe sequencer for two requesters.
// Define IO_ARB_TIMEOUT_EN to build the saturating read-timeout counter and err reporting.
module io_bus_arbiter #(
    parameter int unsigned TO_W = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        io_cs,
    output logic        io_rd,
    output logic        io_wr,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_rdy
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          win;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cs_q, cs_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          rd_abort;

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_MAX = '1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
    logic            err_q, err_d;

    // Saturating increment; abort on the edge where the count would reach its limit.
    assign to_inc   = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
    assign rd_abort = !io_rdy && (to_inc == TO_MAX);

    always_comb begin
        to_cnt_d = '0;
        if (state_q == READ && !io_rdy) begin
            to_cnt_d = to_inc;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == READ && !io_rdy && rd_abort) begin
            err_d = 1'b1;
        end else if (state_d == DONE) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [TO_W-1:0] unused_to_w;

    assign unused_to_w = '0;
    assign rd_abort    = 1'b0;
    assign err         = 1'b0;
`endif

    // Next-state, latched transaction fields and registered output decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        win          = (req0 && req1) ? !last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = win;
                    addr_d       = win ? addr1 : addr0;
                    wdata_d      = win ? wdata1 : wdata0;
                    state_d      = (win ? wr1 : wr0) ? WRITE : READ;
                end
            end
            WRITE: state_d = DONE;
            READ: begin
                if (io_rdy) begin
                    rdata_d = io_rdata;
                    state_d = DONE;
                end else if (rd_abort) begin
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cs_d   = (state_d == WRITE) || (state_d == READ);
        rd_d   = (state_d == READ);
        wr_d   = (state_d == WRITE);
        ack0_d = (state_d == DONE) && !last_grant_d;
        ack1_d = (state_d == DONE) && last_grant_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cs_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign io_cs    = cs_q;
    assign io_rd    = rd_q;
    assign io_wr    = wr_q;
    assign io_addr  = addr_q;
    assign io_wdata = wdata_q;

endmodule
